// File: rtl/ysyx_22040632_dcache_nway.sv
// N-way set-associative write-back/write-allocate data cache with round-robin
// replacement, single-beat bypass for an uncacheable window and a full flush.
module ysyx_22040632_dcache_nway #(
  parameter int unsigned       WAYS       = 2,
  parameter int unsigned       SETS       = 32,
  parameter int unsigned       LINE_BEATS = 8,
  parameter int unsigned       ADDR_W     = 32,
  parameter logic [ADDR_W-1:0] UC_BASE    = 32'h1000_0000,
  parameter logic [ADDR_W-1:0] UC_LIMIT   = 32'hffff_ffff
) (
  input  logic              clk,
  input  logic              rrst_n,
  input  logic              req_valid,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [63:0]       req_wdata,
  input  logic [7:0]        req_wmask,
  output logic              req_ready,
  output logic              resp_valid,
  output logic [63:0]       resp_rdata,
  input  logic              flush_req,
  output logic              flush_done,
  output logic              mem_req_valid,
  input  logic              mem_req_ready,
  output logic              mem_req_write,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_len,
  output logic              mem_wvalid,
  input  logic              mem_wready,
  output logic [63:0]       mem_wdata,
  output logic [7:0]        mem_wstrb,
  output logic              mem_wlast,
  input  logic              mem_rvalid,
  input  logic [63:0]       mem_rdata,
  input  logic              mem_rlast
);
  localparam int unsigned OffW = $clog2(LINE_BEATS * 8);
  localparam int unsigned IdxW = $clog2(SETS);
  localparam int unsigned TagW = ADDR_W - OffW - IdxW;
  localparam int unsigned CntW = $clog2(LINE_BEATS);
  localparam int unsigned WayW = (WAYS > 1) ? $clog2(WAYS) : 1;
  localparam int unsigned PtrW = $clog2(SETS * WAYS);
  localparam logic [CntW-1:0] CntLast = CntW'(LINE_BEATS - 1);
  localparam logic [PtrW-1:0] PtrLast = PtrW'(SETS * WAYS - 1);
  localparam logic [WayW-1:0] WayLast = WayW'(WAYS - 1);

  typedef enum logic [3:0] {
    StIdle, StLookup, StWbAddr, StWbData, StRfAddr, StRfData,
    StUcAddr, StUcData, StFlScan, StFlAddr, StFlData, StFlDone
  } state_e;

  state_e            state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [WayW-1:0]   victim_q, victim_d;
  logic [PtrW-1:0]   fl_p_q, fl_p_d;
  logic [ADDR_W-1:0] addr_q;
  logic [63:0]       wdata_q;
  logic [7:0]        wmask_q;
  logic              write_q;

  logic [SETS-1:0]   valid_q [WAYS];
  logic [SETS-1:0]   dirty_q [WAYS];
  logic [WayW-1:0]   rr_q    [SETS];
  logic [TagW-1:0]   tag_q   [WAYS][SETS];
  logic [63:0]       data_q  [WAYS][SETS][LINE_BEATS];

  logic              accept, store_hit, rf_we, rf_done, fl_clear;
  logic              hit, req_uc, in_flush;
  logic [WayW-1:0]   hit_way, fl_way, line_way, rr_next;
  logic [IdxW-1:0]   req_idx, fl_set, line_set;
  logic [TagW-1:0]   req_tag, line_tag;
  logic [CntW-1:0]   req_word;
  logic [63:0]       hit_word, merged, line_rdata;
  logic              unused_addr;

  assign req_tag     = addr_q[ADDR_W-1 -: TagW];
  assign req_idx     = addr_q[OffW +: IdxW];
  assign req_word    = addr_q[3 +: CntW];
  assign unused_addr = ^addr_q[2:0];
  // Zero-extended compare keeps full-range windows from folding to a constant.
  assign req_uc      = ({1'b0, req_addr} >= {1'b0, UC_BASE}) &&
                       ({1'b0, req_addr} <= {1'b0, UC_LIMIT});
  // Flush pointer is way-major: upper bits pick the way, lower bits the set.
  assign fl_set      = fl_p_q[IdxW-1:0];
  assign fl_way      = WayW'(fl_p_q >> IdxW);
  assign in_flush    = (state_q == StFlScan) || (state_q == StFlAddr) ||
                       (state_q == StFlData) || (state_q == StFlDone);
  assign line_set    = in_flush ? fl_set : req_idx;
  assign line_way    = in_flush ? fl_way : victim_q;
  assign line_tag    = tag_q[line_way][line_set];
  assign line_rdata  = data_q[line_way][line_set][cnt_q];
  assign hit_word    = data_q[hit_way][req_idx][req_word];
  assign rr_next     = (rr_q[req_idx] == WayLast) ? '0 : rr_q[req_idx] + WayW'(1);

  // Tag compare across all ways of the latched set.
  always_comb begin
    hit     = 1'b0;
    hit_way = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (!hit && valid_q[w][req_idx] && (tag_q[w][req_idx] == req_tag)) begin
        hit     = 1'b1;
        hit_way = WayW'(w);
      end
    end
  end

  // Byte-masked store merge into the hit word.
  always_comb begin
    merged = hit_word;
    for (int b = 0; b < 8; b++) begin
      if (wmask_q[b]) merged[b*8 +: 8] = wdata_q[b*8 +: 8];
    end
  end

  // Next-state and output decode.
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    victim_d      = victim_q;
    fl_p_d        = fl_p_q;
    req_ready     = 1'b0;
    resp_valid    = 1'b0;
    resp_rdata    = '0;
    flush_done    = 1'b0;
    mem_req_valid = 1'b0;
    mem_req_write = 1'b0;
    mem_addr      = '0;
    mem_len       = '0;
    mem_wvalid    = 1'b0;
    mem_wdata     = '0;
    mem_wstrb     = '0;
    mem_wlast     = 1'b0;
    accept        = 1'b0;
    store_hit     = 1'b0;
    rf_we         = 1'b0;
    rf_done       = 1'b0;
    fl_clear      = 1'b0;
    unique case (state_q)
      StIdle: begin
        req_ready = !flush_req;
        if (flush_req) begin
          fl_p_d  = '0;
          state_d = StFlScan;
        end else if (req_valid) begin
          accept  = 1'b1;
          state_d = req_uc ? StUcAddr : StLookup;
        end
      end
      StLookup: begin
        if (hit) begin
          resp_valid = 1'b1;
          resp_rdata = write_q ? '0 : hit_word;
          store_hit  = write_q;
          state_d    = StIdle;
        end else begin
          victim_d = rr_q[req_idx];
          state_d  = (valid_q[rr_q[req_idx]][req_idx] && dirty_q[rr_q[req_idx]][req_idx]) ?
                     StWbAddr : StRfAddr;
        end
      end
      StWbAddr, StFlAddr: begin
        mem_req_valid = 1'b1;
        mem_req_write = 1'b1;
        mem_addr      = {line_tag, line_set, {OffW{1'b0}}};
        mem_len       = 8'(LINE_BEATS - 1);
        if (mem_req_ready) state_d = (state_q == StWbAddr) ? StWbData : StFlData;
      end
      StWbData, StFlData: begin
        mem_wvalid = 1'b1;
        mem_wdata  = line_rdata;
        mem_wstrb  = 8'hff;
        mem_wlast  = (cnt_q == CntLast);
        if (mem_wready) begin
          if (cnt_q == CntLast) begin
            cnt_d = '0;
            if (state_q == StWbData) begin
              state_d = StRfAddr;
            end else if (fl_p_q == PtrLast) begin
              state_d = StFlDone;
            end else begin
              fl_p_d  = fl_p_q + PtrW'(1);
              state_d = StFlScan;
            end
          end else begin
            cnt_d = cnt_q + CntW'(1);
          end
        end
      end
      StRfAddr: begin
        mem_req_valid = 1'b1;
        mem_addr      = {req_tag, req_idx, {OffW{1'b0}}};
        mem_len       = 8'(LINE_BEATS - 1);
        if (mem_req_ready) state_d = StRfData;
      end
      StRfData: begin
        if (mem_rvalid) begin
          rf_we = 1'b1;
          cnt_d = cnt_q + CntW'(1);
          if (mem_rlast) begin
            rf_done = 1'b1;
            cnt_d   = '0;
            state_d = StLookup;
          end
        end
      end
      StUcAddr: begin
        mem_req_valid = 1'b1;
        mem_req_write = write_q;
        mem_addr      = {addr_q[ADDR_W-1:3], 3'b000};
        if (mem_req_ready) state_d = StUcData;
      end
      StUcData: begin
        if (write_q) begin
          mem_wvalid = 1'b1;
          mem_wdata  = wdata_q;
          mem_wstrb  = wmask_q;
          mem_wlast  = 1'b1;
          if (mem_wready) begin
            resp_valid = 1'b1;
            state_d    = StIdle;
          end
        end else if (mem_rvalid) begin
          resp_valid = 1'b1;
          resp_rdata = mem_rdata;
          state_d    = StIdle;
        end
      end
      StFlScan: begin
        if (valid_q[fl_way][fl_set] && dirty_q[fl_way][fl_set]) begin
          state_d = StFlAddr;
        end else if (fl_p_q == PtrLast) begin
          state_d = StFlDone;
        end else begin
          fl_p_d = fl_p_q + PtrW'(1);
        end
      end
      StFlDone: begin
        flush_done = 1'b1;
        fl_clear   = 1'b1;
        state_d    = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // Control state and latched request.
  always_ff @(posedge clk or negedge rrst_n) begin
    if (!rrst_n) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      victim_q <= '0;
      fl_p_q   <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
      wmask_q  <= '0;
      write_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      victim_q <= victim_d;
      fl_p_q   <= fl_p_d;
      if (accept) begin
        addr_q  <= req_addr;
        wdata_q <= req_wdata;
        wmask_q <= req_wmask;
        write_q <= req_write;
      end
    end
  end

  // Valid, dirty and replacement pointers; flush end clears everything.
  always_ff @(posedge clk or negedge rrst_n) begin
    if (!rrst_n) begin
      for (int w = 0; w < WAYS; w++) begin
        valid_q[w] <= '0;
        dirty_q[w] <= '0;
      end
      for (int s = 0; s < SETS; s++) rr_q[s] <= '0;
    end else if (fl_clear) begin
      for (int w = 0; w < WAYS; w++) begin
        valid_q[w] <= '0;
        dirty_q[w] <= '0;
      end
      for (int s = 0; s < SETS; s++) rr_q[s] <= '0;
    end else begin
      if (rf_done) begin
        valid_q[victim_q][req_idx] <= 1'b1;
        dirty_q[victim_q][req_idx] <= 1'b0;
        rr_q[req_idx]              <= rr_next;
      end
      if (store_hit) dirty_q[hit_way][req_idx] <= 1'b1;
    end
  end

  // Tag and data arrays; no reset, qualified by the valid bits.
  always_ff @(posedge clk) begin
    if (rf_we)     data_q[victim_q][req_idx][cnt_q]   <= mem_rdata;
    if (rf_done)   tag_q[victim_q][req_idx]           <= req_tag;
    if (store_hit) data_q[hit_way][req_idx][req_word] <= merged;
  end

endmodule

// File: tb/tb_ysyx_22040632_dcache_nway.sv
// Directed bench for the N-way data cache with a hand-driven memory side.
module tb_ysyx_22040632_dcache_nway;
  logic        clk = 1'b0;
  logic        rrst_n;
  logic        req_valid, req_write, req_ready, resp_valid;
  logic [31:0] req_addr;
  logic [63:0] req_wdata, resp_rdata;
  logic [7:0]  req_wmask;
  logic        flush_req, flush_done;
  logic        mem_req_valid, mem_req_ready, mem_req_write;
  logic [31:0] mem_addr;
  logic [7:0]  mem_len;
  logic        mem_wvalid, mem_wready, mem_wlast;
  logic [63:0] mem_wdata;
  logic [7:0]  mem_wstrb;
  logic        mem_rvalid, mem_rlast;
  logic [63:0] mem_rdata;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  // Uncacheable window narrowed so 0x8000_xxxx is cacheable.
  ysyx_22040632_dcache_nway #(
    .WAYS(2), .SETS(32), .LINE_BEATS(8), .ADDR_W(32),
    .UC_BASE(32'h1000_0000), .UC_LIMIT(32'h1fff_ffff)
  ) u_dut (
    .clk(clk), .rrst_n(rrst_n),
    .req_valid(req_valid), .req_write(req_write), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_wmask(req_wmask), .req_ready(req_ready),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata),
    .flush_req(flush_req), .flush_done(flush_done),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
    .mem_req_write(mem_req_write), .mem_addr(mem_addr), .mem_len(mem_len),
    .mem_wvalid(mem_wvalid), .mem_wready(mem_wready), .mem_wdata(mem_wdata),
    .mem_wstrb(mem_wstrb), .mem_wlast(mem_wlast),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata), .mem_rlast(mem_rlast)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic accept(input logic wr, input logic [31:0] a, input logic [63:0] d,
                        input logic [7:0] m);
    int n = 0;
    req_valid = 1'b1; req_write = wr; req_addr = a; req_wdata = d; req_wmask = m;
    #1;
    while (!req_ready && n < 20) begin step(); n++; end
    if (!req_ready) begin
      total++; bad++;
      $display("FAIL accept_%h: req_ready=0 required 1", a);
    end
    step();
    req_valid = 1'b0;
  endtask

  task automatic serve_read(input logic [31:0] a, input logic [63:0] base);
    int n = 0;
    #1;
    while (!mem_req_valid && n < 20) begin step(); n++; end
    total++;
    if (mem_req_valid !== 1'b1 || mem_req_write !== 1'b0 || mem_addr !== a ||
        mem_len !== 8'd7) begin
      bad++;
      $display("FAIL rd_req_%h: valid=%b write=%b addr=%h len=%0d required 1 0 %h 7",
               a, mem_req_valid, mem_req_write, mem_addr, mem_len, a);
    end
    mem_req_ready = 1'b1;
    step();
    mem_req_ready = 1'b0;
    for (int k = 0; k < 8; k++) begin
      mem_rvalid = 1'b1;
      mem_rdata  = base + 64'(k) * 64'h11;
      mem_rlast  = (k == 7);
      step();
    end
    mem_rvalid = 1'b0;
    mem_rlast  = 1'b0;
  endtask

  task automatic serve_write(input logic [31:0] a, input logic [63:0] e [8]);
    int n = 0;
    #1;
    while (!mem_req_valid && n < 100) begin step(); n++; end
    total++;
    if (mem_req_valid !== 1'b1 || mem_req_write !== 1'b1 || mem_addr !== a ||
        mem_len !== 8'd7) begin
      bad++;
      $display("FAIL wb_req_%h: valid=%b write=%b addr=%h len=%0d required 1 1 %h 7",
               a, mem_req_valid, mem_req_write, mem_addr, mem_len, a);
    end
    mem_req_ready = 1'b1;
    step();
    mem_req_ready = 1'b0;
    for (int k = 0; k < 8; k++) begin
      if (k == 3) begin
        mem_wready = 1'b0;
        #1;
        total++;
        if (mem_wvalid !== 1'b1 || mem_wdata !== e[3]) begin
          bad++;
          $display("FAIL wb_stall_%h: wvalid=%b wdata=%h required 1 %h",
                   a, mem_wvalid, mem_wdata, e[3]);
        end
        step();
      end
      mem_wready = 1'b1;
      #1;
      total++;
      if (mem_wvalid !== 1'b1 || mem_wdata !== e[k] || mem_wstrb !== 8'hff ||
          mem_wlast !== (k == 7)) begin
        bad++;
        $display("FAIL wb_beat%0d_%h: wvalid=%b wdata=%h wstrb=%h wlast=%b required 1 %h ff %b",
                 k, a, mem_wvalid, mem_wdata, mem_wstrb, mem_wlast, e[k], (k == 7));
      end
      step();
    end
    mem_wready = 1'b0;
  endtask

  task automatic test_reset();
    rrst_n = 1'b0;
    step(); step();
    total++;
    if (req_ready !== 1'b1 || resp_valid !== 1'b0 || flush_done !== 1'b0 ||
        mem_req_valid !== 1'b0 || mem_wvalid !== 1'b0 || mem_wlast !== 1'b0 ||
        resp_rdata !== 64'h0) begin
      bad++;
      $display("FAIL reset: ready=%b resp=%b done=%b mreq=%b wvalid=%b required 1 0 0 0 0",
               req_ready, resp_valid, flush_done, mem_req_valid, mem_wvalid);
    end
    rrst_n = 1'b1;
    step();
  endtask

  task automatic test_cold_load();
    logic [31:0] ha [2] = '{32'h8000_0040, 32'h8000_0078};
    logic [63:0] hd [2] = '{64'h0, 64'h77};
    accept(1'b0, 32'h8000_0040, 64'h0, 8'h00);
    #1;
    total++;
    if (resp_valid !== 1'b0) begin
      bad++; $display("FAIL cold_miss_resp: resp_valid=%b required 0", resp_valid);
    end
    serve_read(32'h8000_0040, 64'h0);
    #1;
    total++;
    if (resp_valid !== 1'b1 || resp_rdata !== 64'h0) begin
      bad++;
      $display("FAIL cold_resp: valid=%b rdata=%h required 1 0", resp_valid, resp_rdata);
    end
    step();
    for (int i = 0; i < 2; i++) begin
      accept(1'b0, ha[i], 64'h0, 8'h00);
      #1;
      total++;
      if (resp_valid !== 1'b1 || resp_rdata !== hd[i] || mem_req_valid !== 1'b0) begin
        bad++;
        $display("FAIL hit_load_%h: valid=%b rdata=%h mreq=%b required 1 %h 0",
                 ha[i], resp_valid, resp_rdata, mem_req_valid, hd[i]);
      end
      step();
    end
  endtask

  task automatic test_store_merge();
    logic [31:0] la [3] = '{32'h8000_0048, 32'h8000_0050, 32'h8000_0040};
    logic [63:0] ld [3] = '{64'hAABB, 64'h1234_5678_0000_0022, 64'h0};
    accept(1'b1, 32'h8000_0048, 64'hAABB, 8'h03);
    #1;
    total++;
    if (resp_valid !== 1'b1 || mem_req_valid !== 1'b0) begin
      bad++; $display("FAIL store_hit0: resp_valid=%b mreq=%b required 1 0",
                      resp_valid, mem_req_valid);
    end
    step();
    accept(1'b1, 32'h8000_0050, 64'h1234_5678_9ABC_DEF0, 8'hF0);
    #1;
    total++;
    if (resp_valid !== 1'b1) begin
      bad++; $display("FAIL store_hit1: resp_valid=%b required 1", resp_valid);
    end
    step();
    for (int i = 0; i < 3; i++) begin
      accept(1'b0, la[i], 64'h0, 8'h00);
      #1;
      total++;
      if (resp_valid !== 1'b1 || resp_rdata !== ld[i]) begin
        bad++;
        $display("FAIL merge_load_%h: valid=%b rdata=%h required 1 %h",
                 la[i], resp_valid, resp_rdata, ld[i]);
      end
      step();
    end
  endtask

  task automatic test_evict();
    logic [63:0] e [8] = '{64'h0, 64'hAABB, 64'h1234_5678_0000_0022, 64'h33,
                           64'h44, 64'h55, 64'h66, 64'h77};
    accept(1'b0, 32'h8000_0840, 64'h0, 8'h00);
    serve_read(32'h8000_0840, 64'h100);
    #1;
    total++;
    if (resp_valid !== 1'b1 || resp_rdata !== 64'h100) begin
      bad++; $display("FAIL second_tag: valid=%b rdata=%h required 1 100",
                      resp_valid, resp_rdata);
    end
    step();
    accept(1'b0, 32'h8000_1040, 64'h0, 8'h00);
    serve_write(32'h8000_0040, e);
    serve_read(32'h8000_1040, 64'h200);
    #1;
    total++;
    if (resp_valid !== 1'b1 || resp_rdata !== 64'h200) begin
      bad++; $display("FAIL third_tag: valid=%b rdata=%h required 1 200",
                      resp_valid, resp_rdata);
    end
    step();
    accept(1'b0, 32'h8000_0840, 64'h0, 8'h00);
    #1;
    total++;
    if (resp_valid !== 1'b1 || resp_rdata !== 64'h100) begin
      bad++; $display("FAIL survivor_hit: valid=%b rdata=%h required 1 100",
                      resp_valid, resp_rdata);
    end
    step();
  endtask

  task automatic test_uncached();
    accept(1'b1, 32'h1000_0003, 64'h1122_3344_5566_7788, 8'h08);
    #1;
    total++;
    if (mem_req_valid !== 1'b1 || mem_req_write !== 1'b1 || mem_addr !== 32'h1000_0000 ||
        mem_len !== 8'd0) begin
      bad++;
      $display("FAIL uc_wr_req: valid=%b write=%b addr=%h len=%0d required 1 1 10000000 0",
               mem_req_valid, mem_req_write, mem_addr, mem_len);
    end
    mem_req_ready = 1'b1;
    step();
    mem_req_ready = 1'b0;
    #1;
    total++;
    if (mem_wvalid !== 1'b1 || mem_wstrb !== 8'h08 || mem_wlast !== 1'b1 ||
        mem_wdata !== 64'h1122_3344_5566_7788 || resp_valid !== 1'b0) begin
      bad++;
      $display("FAIL uc_wr_beat: wvalid=%b wstrb=%h wlast=%b wdata=%h resp=%b required 1 08 1",
               mem_wvalid, mem_wstrb, mem_wlast, mem_wdata, resp_valid);
    end
    step();
    mem_wready = 1'b1;
    #1;
    total++;
    if (resp_valid !== 1'b1 || resp_rdata !== 64'h0) begin
      bad++; $display("FAIL uc_wr_resp: valid=%b rdata=%h required 1 0", resp_valid, resp_rdata);
    end
    step();
    mem_wready = 1'b0;
    accept(1'b0, 32'h1000_0010, 64'h0, 8'h00);
    #1;
    total++;
    if (mem_req_valid !== 1'b1 || mem_req_write !== 1'b0 || mem_addr !== 32'h1000_0010 ||
        mem_len !== 8'd0) begin
      bad++;
      $display("FAIL uc_rd_req: valid=%b write=%b addr=%h len=%0d required 1 0 10000010 0",
               mem_req_valid, mem_req_write, mem_addr, mem_len);
    end
    mem_req_ready = 1'b1;
    step();
    mem_req_ready = 1'b0;
    #1;
    total++;
    if (resp_valid !== 1'b0) begin
      bad++; $display("FAIL uc_rd_wait: resp_valid=%b required 0", resp_valid);
    end
    step();
    mem_rvalid = 1'b1; mem_rlast = 1'b1; mem_rdata = 64'hDEAD_BEEF_0BAD_F00D;
    #1;
    total++;
    if (resp_valid !== 1'b1 || resp_rdata !== 64'hDEAD_BEEF_0BAD_F00D) begin
      bad++; $display("FAIL uc_rd_resp: valid=%b rdata=%h required 1 deadbeef0badf00d",
                      resp_valid, resp_rdata);
    end
    step();
    mem_rvalid = 1'b0; mem_rlast = 1'b0;
    accept(1'b0, 32'h8000_1040, 64'h0, 8'h00);
    #1;
    total++;
    if (resp_valid !== 1'b1 || resp_rdata !== 64'h200 || mem_req_valid !== 1'b0) begin
      bad++; $display("FAIL uc_untouched: valid=%b rdata=%h mreq=%b required 1 200 0",
                      resp_valid, resp_rdata, mem_req_valid);
    end
    step();
  endtask

  task automatic test_flush();
    logic [63:0] e0 [8] = '{64'hFFFF_0000_FFFF_0000, 64'h211, 64'h222, 64'h233,
                            64'h244, 64'h255, 64'h266, 64'h277};
    logic [63:0] e1 [8] = '{64'h100, 64'h15A, 64'h122, 64'h133,
                            64'h144, 64'h155, 64'h166, 64'h177};
    int n = 0;
    int extra = 0;
    accept(1'b1, 32'h8000_1040, 64'hFFFF_0000_FFFF_0000, 8'hFF);
    step();
    accept(1'b1, 32'h8000_0848, 64'h5A, 8'h01);
    step();
    // Flush and a request together: the flush must win.
    flush_req = 1'b1;
    req_valid = 1'b1; req_write = 1'b0; req_addr = 32'h8000_1040;
    #1;
    total++;
    if (req_ready !== 1'b0) begin
      bad++; $display("FAIL flush_priority: req_ready=%b required 0", req_ready);
    end
    step();
    flush_req = 1'b0;
    req_valid = 1'b0;
    serve_write(32'h8000_1040, e0);
    serve_write(32'h8000_0840, e1);
    while (!flush_done && n < 100) begin
      if (mem_req_valid) extra++;
      step();
      n++;
    end
    total++;
    if (flush_done !== 1'b1 || extra != 0) begin
      bad++; $display("FAIL flush_end: done=%b extra_bursts=%0d required 1 0", flush_done, extra);
    end
    step();
    total++;
    if (flush_done !== 1'b0 || req_ready !== 1'b1 || resp_valid !== 1'b0) begin
      bad++; $display("FAIL flush_pulse: done=%b ready=%b resp=%b required 0 1 0",
                      flush_done, req_ready, resp_valid);
    end
    // Clean cache: SETS*WAYS+1 cycles from acceptance to the done pulse.
    flush_req = 1'b1;
    step();
    flush_req = 1'b0;
    n = 1;
    extra = 0;
    while (!flush_done && n < 200) begin
      if (mem_req_valid) extra++;
      step();
      n++;
    end
    total++;
    if (n != 65 || extra != 0) begin
      bad++; $display("FAIL clean_flush_len: cycles=%0d bursts=%0d required 65 0", n, extra);
    end
    step();
    accept(1'b0, 32'h8000_1040, 64'h0, 8'h00);
    #1;
    total++;
    if (resp_valid !== 1'b0) begin
      bad++; $display("FAIL flushed_miss: resp_valid=%b required 0", resp_valid);
    end
    serve_read(32'h8000_1040, 64'h300);
    #1;
    total++;
    if (resp_valid !== 1'b1 || resp_rdata !== 64'h300) begin
      bad++; $display("FAIL flushed_refill: valid=%b rdata=%h required 1 300",
                      resp_valid, resp_rdata);
    end
    step();
  endtask

  task automatic test_reset_mid_wb();
    logic [31:0] ma [2] = '{32'h8000_0840, 32'h8000_1040};
    logic [63:0] mb [2] = '{64'h500, 64'h600};
    int n = 0;
    accept(1'b1, 32'h8000_1040, 64'h0123, 8'hFF);
    step();
    accept(1'b0, 32'h8000_0840, 64'h0, 8'h00);
    serve_read(32'h8000_0840, 64'h400);
    step();
    accept(1'b0, 32'h8000_0040, 64'h0, 8'h00);
    #1;
    while (!mem_req_valid && n < 20) begin step(); n++; end
    total++;
    if (mem_req_valid !== 1'b1 || mem_req_write !== 1'b1 || mem_addr !== 32'h8000_1040) begin
      bad++; $display("FAIL rst_wb_req: valid=%b write=%b addr=%h required 1 1 80001040",
                      mem_req_valid, mem_req_write, mem_addr);
    end
    mem_req_ready = 1'b1;
    step();
    mem_req_ready = 1'b0;
    mem_wready = 1'b1;
    step();
    mem_wready = 1'b0;
    #1;
    total++;
    if (mem_wvalid !== 1'b1) begin
      bad++; $display("FAIL rst_pre_wvalid: wvalid=%b required 1", mem_wvalid);
    end
    rrst_n = 1'b0;
    #1;
    total++;
    if (mem_wvalid !== 1'b0 || mem_req_valid !== 1'b0 || req_ready !== 1'b1) begin
      bad++; $display("FAIL rst_drop: wvalid=%b mreq=%b ready=%b required 0 0 1",
                      mem_wvalid, mem_req_valid, req_ready);
    end
    step();
    rrst_n = 1'b1;
    step();
    for (int i = 0; i < 2; i++) begin
      accept(1'b0, ma[i], 64'h0, 8'h00);
      #1;
      total++;
      if (resp_valid !== 1'b0) begin
        bad++; $display("FAIL post_rst_miss_%h: resp_valid=%b required 0", ma[i], resp_valid);
      end
      serve_read(ma[i], mb[i]);
      #1;
      total++;
      if (resp_valid !== 1'b1 || resp_rdata !== mb[i]) begin
        bad++; $display("FAIL post_rst_refill_%h: valid=%b rdata=%h required 1 %h",
                        ma[i], resp_valid, resp_rdata, mb[i]);
      end
      step();
    end
  endtask

  initial begin
    rrst_n = 1'b0;
    req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0; req_wmask = '0;
    flush_req = 1'b0;
    mem_req_ready = 1'b0; mem_wready = 1'b0;
    mem_rvalid = 1'b0; mem_rdata = '0; mem_rlast = 1'b0;
    test_reset();
    test_cold_load();
    test_store_merge();
    test_evict();
    test_uncached();
    test_flush();
    test_reset_mid_wb();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, bad=%0d", bad);
    $fatal(1);
  end

endmodule
